// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops the ALU/LSB CDBs for wakeup and issues the lowest ready entry each cycle.
`ifndef OP_NULL
`define OP_NULL 6'd0
`endif

module alu_rs #(
  parameter int RS_SIZE      = 16,
  parameter int ROB_SIZE_LOG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    disp_valid,
  input  logic [5:0]              disp_op,
  input  logic [31:0]             disp_vj,
  input  logic [31:0]             disp_vk,
  input  logic [ROB_SIZE_LOG-1:0] disp_qj,
  input  logic [ROB_SIZE_LOG-1:0] disp_qk,
  input  logic                    disp_qj_pend,
  input  logic                    disp_qk_pend,
  input  logic [31:0]             disp_imm,
  input  logic [ROB_SIZE_LOG-1:0] disp_ROBid,
  input  logic [31:0]             disp_pc,
  output logic                    rs_full,
  input  logic                    cdb_alu_enable,
  input  logic [31:0]             cdb_alu_value,
  input  logic [ROB_SIZE_LOG-1:0] cdb_alu_ROBid,
  input  logic                    cdb_lsb_enable,
  input  logic [31:0]             cdb_lsb_value,
  input  logic [ROB_SIZE_LOG-1:0] cdb_lsb_ROBid,
  output logic                    RS_valid,
  output logic [5:0]              RS_op,
  output logic [31:0]             RS_vj,
  output logic [31:0]             RS_vk,
  output logic [31:0]             RS_imm,
  output logic [31:0]             RS_curpc,
  output logic [ROB_SIZE_LOG-1:0] RS_ROBid
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int RSL = ROB_SIZE_LOG;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_pend;
  logic [RS_SIZE-1:0] qk_pend;
  logic [5:0]         op     [RS_SIZE];
  logic [31:0]        vj     [RS_SIZE];
  logic [31:0]        vk     [RS_SIZE];
  logic [RSL-1:0]     qj     [RS_SIZE];
  logic [RSL-1:0]     qk     [RS_SIZE];
  logic [31:0]        imm    [RS_SIZE];
  logic [RSL-1:0]     rob_id [RS_SIZE];
  logic [31:0]        pc     [RS_SIZE];

  logic          free_ok, issue_ok;
  logic [IW-1:0] free_idx, issue_idx;
  logic [IW:0]   busy_cnt;

  // Resolve one operand against both CDBs; returns {pend, value}. ALU bus wins a tie.
  function automatic logic [32:0] snoop(
    input logic           pend,
    input logic [RSL-1:0] tag,
    input logic [31:0]    value,
    input logic           a_en,
    input logic [RSL-1:0] a_tag,
    input logic [31:0]    a_val,
    input logic           l_en,
    input logic [RSL-1:0] l_tag,
    input logic [31:0]    l_val
  );
    if (pend && a_en && tag == a_tag)      return {1'b0, a_val};
    else if (pend && l_en && tag == l_tag) return {1'b0, l_val};
    else                                   return {pend, value};
  endfunction

  // Descending scan leaves the lowest free / lowest ready index selected.
  always_comb begin
    free_ok   = 1'b0;
    free_idx  = '0;
    issue_ok  = 1'b0;
    issue_idx = '0;
    busy_cnt  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (busy[i] && !qj_pend[i] && !qk_pend[i]) begin
        issue_ok  = 1'b1;
        issue_idx = IW'(i);
      end
      busy_cnt = busy_cnt + (IW+1)'(busy[i]);
    end
  end

  assign rs_full = (busy_cnt >= (IW+1)'(RS_SIZE - 1));

  // Entry payload: wakeup for all entries, then dispatch overrides the chosen free slot.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int e = 0; e < RS_SIZE; e++) begin
        {qj_pend[e], vj[e]} <= snoop(qj_pend[e], qj[e], vj[e], cdb_alu_enable, cdb_alu_ROBid,
                                     cdb_alu_value, cdb_lsb_enable, cdb_lsb_ROBid, cdb_lsb_value);
        {qk_pend[e], vk[e]} <= snoop(qk_pend[e], qk[e], vk[e], cdb_alu_enable, cdb_alu_ROBid,
                                     cdb_alu_value, cdb_lsb_enable, cdb_lsb_ROBid, cdb_lsb_value);
      end
      if (disp_valid && free_ok) begin
        op[free_idx]     <= disp_op;
        qj[free_idx]     <= disp_qj;
        qk[free_idx]     <= disp_qk;
        imm[free_idx]    <= disp_imm;
        rob_id[free_idx] <= disp_ROBid;
        pc[free_idx]     <= disp_pc;
        {qj_pend[free_idx], vj[free_idx]} <= snoop(disp_qj_pend, disp_qj, disp_vj,
          cdb_alu_enable, cdb_alu_ROBid, cdb_alu_value, cdb_lsb_enable, cdb_lsb_ROBid, cdb_lsb_value);
        {qk_pend[free_idx], vk[free_idx]} <= snoop(disp_qk_pend, disp_qk, disp_vk,
          cdb_alu_enable, cdb_alu_ROBid, cdb_alu_value, cdb_lsb_enable, cdb_lsb_ROBid, cdb_lsb_value);
      end
    end
  end

  // Occupancy and issue bus; the free slot comes from registered busy, so an entry
  // freed by issue on this edge cannot be refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      RS_valid  <= 1'b0;
      RS_op     <= `OP_NULL;
      RS_vj     <= '0;
      RS_vk     <= '0;
      RS_imm    <= '0;
      RS_curpc  <= '0;
      RS_ROBid  <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy     <= '0;
        RS_valid <= 1'b0;
        RS_op    <= `OP_NULL;
      end else begin
        if (issue_ok) begin
          busy[issue_idx] <= 1'b0;
          RS_valid        <= 1'b1;
          RS_op           <= op[issue_idx];
          RS_vj           <= vj[issue_idx];
          RS_vk           <= vk[issue_idx];
          RS_imm          <= imm[issue_idx];
          RS_curpc        <= pc[issue_idx];
          RS_ROBid        <= rob_id[issue_idx];
        end else begin
          RS_valid <= 1'b0;
          RS_op    <= `OP_NULL;
        end
        if (disp_valid && free_ok) busy[free_idx] <= 1'b1;
      end
    end
  end
endmodule
